// File: rtl/ex_lvds_tx.sv
// Parallel-to-serial LVDS transmitter: trains with a fixed preamble after reset, then
// serializes queued words LSB first on fixed 8-clock boundaries, filling gaps with idle words.
module ex_lvds_tx #(
    parameter int unsigned TRAIN_WORDS   = 4,
    parameter logic [7:0]  TRAIN_PATTERN = 8'hA5,
    parameter logic [7:0]  IDLE_WORD     = 8'h00
) (
    input  logic       lvds_clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       lvds_dout,
    output logic       word_start,
    output logic       training,
    output logic       underrun
);

    typedef enum logic {
        S_TRAIN,
        S_RUN
    } state_t;

    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_sh;
    logic [3:0] r_train_cnt;
    logic       r_underrun;
    logic [7:0] r_fifo [2];
    logic       r_rd_ptr;
    logic       r_wr_ptr;
    logic [1:0] r_count;

    logic       w_push;
    logic       w_boundary;
    logic       w_run_next;
    logic       w_pop;
    logic       w_bypass;
    logic       w_wr;
    logic       w_idle;
    logic [7:0] w_next_word;

    assign din_ready  = !rst && (r_count < 2'd2);
    assign w_push     = din_valid && din_ready;
    assign w_boundary = (r_bit_cnt == 3'd7);
    // The last training boundary already follows the RUN loading rules.
    assign w_run_next = (r_state == S_RUN) || (r_train_cnt == 4'(TRAIN_WORDS));

    always_comb begin
        w_pop       = 1'b0;
        w_bypass    = 1'b0;
        w_idle      = 1'b0;
        w_next_word = TRAIN_PATTERN;
        if (w_boundary && w_run_next) begin
            if (r_count != 2'd0) begin
                w_pop       = 1'b1;
                w_next_word = r_fifo[r_rd_ptr];
            end else if (w_push) begin
                // Empty FIFO with a word arriving on the boundary edge: load it directly.
                w_bypass    = 1'b1;
                w_next_word = din;
            end else begin
                w_idle      = 1'b1;
                w_next_word = IDLE_WORD;
            end
        end
    end

    assign w_wr = w_push && !w_bypass;

    always_ff @(posedge lvds_clk) begin
        if (rst) begin
            r_state     <= S_TRAIN;
            r_bit_cnt   <= '0;
            r_sh        <= TRAIN_PATTERN;
            r_train_cnt <= 4'd1;
            r_underrun  <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_count     <= '0;
        end else begin
            r_underrun <= w_idle;
            if (!w_boundary) begin
                r_sh      <= r_sh >> 1;
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end else begin
                r_bit_cnt <= '0;
                r_sh      <= w_next_word;
                if (r_state == S_TRAIN) begin
                    if (w_run_next) begin
                        r_state <= S_RUN;
                    end else begin
                        r_train_cnt <= r_train_cnt + 4'd1;
                    end
                end
            end

            if (w_wr) begin
                r_fifo[r_wr_ptr] <= din;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign lvds_dout  = r_sh[0];
    assign word_start = (r_bit_cnt == 3'd0);
    assign training   = (r_state == S_TRAIN);
    assign underrun   = r_underrun;

endmodule
